// File: rtl/apb_arbiter_master.sv
// APB master shared by two requesters with round-robin arbitration.
// One transfer in flight at a time; every output comes straight from a flop.
module apb_arbiter_master #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        pclk,
  input  logic        prst,
  input  logic        req0_valid,
  input  logic        req0_wr,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req0_wdata,
  output logic        req0_ack,
  output logic [31:0] req0_rdata,
  output logic        req0_err,
  input  logic        req1_valid,
  input  logic        req1_wr,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req1_wdata,
  output logic        req1_ack,
  output logic [31:0] req1_rdata,
  output logic        req1_err,
  output logic        p_sel,
  output logic        p_en,
  output logic        p_wr,
  output logic [31:0] p_addr,
  output logic [31:0] pw_data,
  input  logic        p_ready,
  input  logic        pslverr,
  input  logic [31:0] pr_data
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t        state_q;
  logic          last_grant_q;
  logic          grant_q;
  logic [CW-1:0] cnt_q;
  logic          p_sel_q;
  logic          p_en_q;
  logic          p_wr_q;
  logic [31:0]   p_addr_q;
  logic [31:0]   pw_data_q;
  logic          ack0_q;
  logic          ack1_q;
  logic [31:0]   rdata0_q;
  logic [31:0]   rdata1_q;
  logic          err0_q;
  logic          err1_q;

  logic          gnt_vld_d;
  logic          gnt_idx_d;
  logic          sel_wr_d;
  logic [31:0]   sel_addr_d;
  logic [31:0]   sel_wdata_d;
  logic [CW-1:0] cnt_inc_d;
  logic          timeout_d;
  logic [31:0]   rdata_d;
  logic          err_d;

  // Round-robin pick: on contention the requester not served last wins.
  always_comb begin
    gnt_vld_d = 1'b0;
    gnt_idx_d = last_grant_q;
    if (req0_valid && req1_valid) begin
      gnt_vld_d = 1'b1;
      gnt_idx_d = ~last_grant_q;
    end else if (req0_valid) begin
      gnt_vld_d = 1'b1;
      gnt_idx_d = 1'b0;
    end else if (req1_valid) begin
      gnt_vld_d = 1'b1;
      gnt_idx_d = 1'b1;
    end else begin
      gnt_vld_d = 1'b0;
      gnt_idx_d = last_grant_q;
    end
  end

  assign sel_wr_d    = gnt_idx_d ? req1_wr    : req0_wr;
  assign sel_addr_d  = gnt_idx_d ? req1_addr  : req0_addr;
  assign sel_wdata_d = gnt_idx_d ? req1_wdata : req0_wdata;

  // A slave answering on the very cycle the count would expire still wins.
  assign cnt_inc_d = cnt_q + CW'(1);
  assign timeout_d = (cnt_inc_d == CW'(TIMEOUT));
  assign rdata_d   = (p_ready && !p_wr_q) ? pr_data : 32'h0000_0000;
  assign err_d     = p_ready ? pslverr : 1'b1;

  always_ff @(posedge pclk) begin
    if (prst) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      cnt_q        <= '0;
      p_sel_q      <= 1'b0;
      p_en_q       <= 1'b0;
      p_wr_q       <= 1'b0;
      p_addr_q     <= 32'h0000_0000;
      pw_data_q    <= 32'h0000_0000;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      rdata0_q     <= 32'h0000_0000;
      rdata1_q     <= 32'h0000_0000;
      err0_q       <= 1'b0;
      err1_q       <= 1'b0;
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (gnt_vld_d) begin
            state_q      <= S_SETUP;
            grant_q      <= gnt_idx_d;
            last_grant_q <= gnt_idx_d;
            p_wr_q       <= sel_wr_d;
            p_addr_q     <= sel_addr_d;
            pw_data_q    <= sel_wdata_d;
            p_sel_q      <= 1'b1;
            p_en_q       <= 1'b0;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_SETUP: begin
          state_q <= S_ACCESS;
          p_en_q  <= 1'b1;
          cnt_q   <= '0;
        end
        S_ACCESS: begin
          if (!p_ready) begin
            cnt_q <= cnt_inc_d;
          end else begin
            cnt_q <= cnt_q;
          end
          if (p_ready || timeout_d) begin
            state_q <= S_DONE;
            p_sel_q <= 1'b0;
            p_en_q  <= 1'b0;
            if (grant_q) begin
              ack1_q   <= 1'b1;
              rdata1_q <= rdata_d;
              err1_q   <= err_d;
            end else begin
              ack0_q   <= 1'b1;
              rdata0_q <= rdata_d;
              err0_q   <= err_d;
            end
          end else begin
            state_q <= S_ACCESS;
          end
        end
        S_DONE: begin
          state_q  <= S_IDLE;
          cnt_q    <= '0;
          rdata0_q <= 32'h0000_0000;
          rdata1_q <= 32'h0000_0000;
          err0_q   <= 1'b0;
          err1_q   <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          p_sel_q <= 1'b0;
          p_en_q  <= 1'b0;
        end
      endcase
    end
  end

  assign p_sel      = p_sel_q;
  assign p_en       = p_en_q;
  assign p_wr       = p_wr_q;
  assign p_addr     = p_addr_q;
  assign pw_data    = pw_data_q;
  assign req0_ack   = ack0_q;
  assign req1_ack   = ack1_q;
  assign req0_rdata = rdata0_q;
  assign req1_rdata = rdata1_q;
  assign req0_err   = err0_q;
  assign req1_err   = err1_q;

endmodule

// File: tb/tb_apb_arbiter_master.sv
// Scoreboard bench for apb_arbiter_master: per-scenario tasks, a small APB
// slave model with programmable wait states, expected acks queued at request time.
module tb_apb_arbiter_master;

  logic        pclk = 1'b0;
  logic        prst = 1'b1;
  logic        req0_valid, req0_wr, req1_valid, req1_wr;
  logic [31:0] req0_addr, req0_wdata, req1_addr, req1_wdata;
  logic        req0_ack, req0_err, req1_ack, req1_err;
  logic [31:0] req0_rdata, req1_rdata;
  logic        p_sel, p_en, p_wr, p_ready, pslverr;
  logic [31:0] p_addr, pw_data, pr_data;

  logic [31:0] rdata_cfg = 32'h0;
  logic        slverr_cfg = 1'b0;
  logic        xor_mode = 1'b0;
  int          wait_cfg = 0;
  int          wait_cnt = 0;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [1:0]  ack;
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb[$];

  always #5 pclk = ~pclk;

  apb_arbiter_master #(.TIMEOUT(16)) dut (
    .pclk(pclk), .prst(prst),
    .req0_valid(req0_valid), .req0_wr(req0_wr), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_ack(req0_ack), .req0_rdata(req0_rdata), .req0_err(req0_err),
    .req1_valid(req1_valid), .req1_wr(req1_wr), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_ack(req1_ack), .req1_rdata(req1_rdata), .req1_err(req1_err),
    .p_sel(p_sel), .p_en(p_en), .p_wr(p_wr), .p_addr(p_addr), .pw_data(pw_data),
    .p_ready(p_ready), .pslverr(pslverr), .pr_data(pr_data)
  );

  // Slave: ready after wait_cfg low ACCESS cycles
  assign p_ready = p_sel && p_en && (wait_cnt >= wait_cfg);
  assign pslverr = slverr_cfg;
  assign pr_data = xor_mode ? (rdata_cfg ^ p_addr) : rdata_cfg;

  always @(posedge pclk) begin
    if (p_sel && p_en && !p_ready) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic wait_setup(input int budget, output logic got, output logic saw_ack);
    got = 1'b0;
    saw_ack = 1'b0;
    for (int c = 0; c < budget && !got; c++) begin
      tick();
      if (req0_ack || req1_ack) saw_ack = 1'b1;
      if (p_sel && !p_en) got = 1'b1;
    end
  endtask

  task automatic wait_ack(input int budget, output logic got, output logic [1:0] ackv,
                          output logic [31:0] rd, output logic er);
    got = 1'b0; ackv = 2'b00; rd = 32'h0; er = 1'b0;
    for (int c = 0; c < budget && !got; c++) begin
      tick();
      if (req0_ack || req1_ack) begin
        got  = 1'b1;
        ackv = {req1_ack, req0_ack};
        rd   = req1_ack ? req1_rdata : req0_rdata;
        er   = req1_ack ? req1_err : req0_err;
      end
    end
  endtask

  // Called in the SETUP cycle; returns in the cycle after the last ACCESS cycle.
  task automatic run_access(input int budget, input logic toggle1, output int n,
                            output logic stable, output logic [1:0] ackv,
                            output logic [31:0] rd, output logic er);
    logic [64:0] ref_v;
    ref_v = {p_wr, p_addr, pw_data};
    n = 0; stable = 1'b1; ackv = 2'b00; rd = 32'h0; er = 1'b0;
    for (int c = 0; c < budget; c++) begin
      tick();
      if (toggle1) begin
        req1_valid = 1'($urandom_range(1, 0));
        req1_addr  = $urandom();
      end
      if (p_sel && p_en) begin
        n++;
        if ({p_wr, p_addr, pw_data} !== ref_v) stable = 1'b0;
      end else begin
        ackv = {req1_ack, req0_ack};
        rd   = req1_ack ? req1_rdata : req0_rdata;
        er   = req1_ack ? req1_err : req0_err;
        break;
      end
    end
  endtask

  task automatic test_reset();
    prst = 1'b1;
    tick();
    tick();
    total++;
    if ({p_sel, p_en, p_wr, req0_ack, req1_ack, req0_err, req1_err} !== 7'b0) begin
      bad++;
      $display("FAIL reset_ctrl: got %b want 0000000",
               {p_sel, p_en, p_wr, req0_ack, req1_ack, req0_err, req1_err});
    end
    total++;
    if ({p_addr, pw_data, req0_rdata, req1_rdata} !== 128'h0) begin
      bad++;
      $display("FAIL reset_data: got %h %h %h %h want all zero", p_addr, pw_data, req0_rdata, req1_rdata);
    end
    prst = 1'b0;
    tick();
    total++;
    if (p_sel !== 1'b0) begin bad++; $display("FAIL idle_no_req: p_sel got %b want 0", p_sel); end
  endtask

  task automatic test_single_read();
    exp_t e;
    xor_mode = 1'b0; rdata_cfg = 32'hA5A5_0001; wait_cfg = 0; slverr_cfg = 1'b0;
    req0_valid = 1'b1; req0_wr = 1'b0; req0_addr = 32'h10; req0_wdata = 32'h0;
    sb.push_back({2'b01, 32'hA5A5_0001, 1'b0});
    tick();
    total++;
    if ({p_sel, p_en, p_wr, p_addr} !== {3'b100, 32'h10}) begin
      bad++; $display("FAIL rd_setup: got %b %h want 100 00000010", {p_sel, p_en, p_wr}, p_addr);
    end
    tick();
    total++;
    if ({p_sel, p_en} !== 2'b11) begin bad++; $display("FAIL rd_access: got %b want 11", {p_sel, p_en}); end
    tick();
    e = sb.pop_front();
    total++;
    if ({req1_ack, req0_ack, req0_rdata, req0_err} !== e) begin
      bad++; $display("FAIL rd_ack: got %b %h %b want %b %h %b",
                      {req1_ack, req0_ack}, req0_rdata, req0_err, e.ack, e.rdata, e.err);
    end
    total++;
    if ({p_sel, p_en, p_addr} !== {2'b00, 32'h10}) begin
      bad++; $display("FAIL rd_done_bus: got %b %h want 00 00000010", {p_sel, p_en}, p_addr);
    end
    req0_valid = 1'b0;
    tick();
    total++;
    if ({req1_ack, req0_ack} !== 2'b00) begin bad++; $display("FAIL rd_ack_pulse: got %b want 00", {req1_ack, req0_ack}); end
  endtask

  task automatic test_round_robin();
    exp_t e;
    logic got, sa, er;
    logic [1:0] av;
    logic [31:0] rd, a;
    prst = 1'b1; tick(); prst = 1'b0;
    xor_mode = 1'b1; rdata_cfg = 32'h1234_0000; wait_cfg = 1; slverr_cfg = 1'b0;
    req0_valid = 1'b1; req0_wr = 1'b0; req0_addr = 32'h100; req0_wdata = 32'h0;
    req1_valid = 1'b1; req1_wr = 1'b0; req1_addr = 32'h200; req1_wdata = 32'h0;
    for (int i = 0; i < 4; i++) begin
      a = i[0] ? 32'h200 : 32'h100;
      sb.push_back({(i[0] ? 2'b10 : 2'b01), 32'h1234_0000 ^ a, 1'b0});
      wait_setup(10, got, sa);
      total++;
      if (!got || p_addr !== a) begin bad++; $display("FAIL rr_addr%0d: got %h want %h", i, p_addr, a); end
      wait_ack(10, got, av, rd, er);
      e = sb.pop_front();
      total++;
      if ({got, av, rd, er} !== {1'b1, e}) begin
        bad++; $display("FAIL rr_ack%0d: got %b %b %h %b want 1 %b %h %b", i, got, av, rd, er, e.ack, e.rdata, e.err);
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0; xor_mode = 1'b0;
    tick();
  endtask

  task automatic test_wait_write_err();
    exp_t e;
    logic got, sa, st, er;
    logic [1:0] av;
    logic [31:0] rd;
    int n;
    wait_cfg = 3; slverr_cfg = 1'b1; rdata_cfg = 32'h7777_7777;
    req0_valid = 1'b1; req0_wr = 1'b1; req0_addr = 32'h44; req0_wdata = 32'hDEAD_BEEF;
    sb.push_back({2'b01, 32'h0, 1'b1});
    wait_setup(10, got, sa);
    run_access(30, 1'b0, n, st, av, rd, er);
    total++;
    if (!got || n != 4 || !st) begin bad++; $display("FAIL wr_wait: setup %b cycles %0d stable %b want 1 4 1", got, n, st); end
    total++;
    if ({p_wr, p_addr, pw_data} !== {1'b1, 32'h44, 32'hDEAD_BEEF}) begin
      bad++; $display("FAIL wr_bus: got %b %h %h want 1 00000044 deadbeef", p_wr, p_addr, pw_data);
    end
    e = sb.pop_front();
    total++;
    if ({av, rd, er} !== e) begin bad++; $display("FAIL wr_ack: got %b %h %b want %b %h %b", av, rd, er, e.ack, e.rdata, e.err); end
    req0_valid = 1'b0; slverr_cfg = 1'b0;
    tick();
  endtask

  task automatic test_timeout_edge();
    exp_t e;
    logic got, sa, st, er;
    logic [1:0] av;
    logic [31:0] rd;
    int n;
    wait_cfg = 15; slverr_cfg = 1'b0; rdata_cfg = 32'hCAFE_F00D;
    req0_valid = 1'b1; req0_wr = 1'b0; req0_addr = 32'h60;
    sb.push_back({2'b01, 32'hCAFE_F00D, 1'b0});
    wait_setup(10, got, sa);
    run_access(40, 1'b0, n, st, av, rd, er);
    total++;
    if (!got || n != 16) begin bad++; $display("FAIL to_edge_len: cycles %0d want 16", n); end
    e = sb.pop_front();
    total++;
    if ({av, rd, er} !== e) begin bad++; $display("FAIL to_edge_ack: got %b %h %b want %b %h %b", av, rd, er, e.ack, e.rdata, e.err); end
    req0_valid = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    exp_t e;
    logic got, sa, st, er;
    logic [1:0] av;
    logic [31:0] rd;
    int n;
    wait_cfg = 1000; rdata_cfg = 32'h1111_2222;
    req1_valid = 1'b1; req1_wr = 1'b0; req1_addr = 32'h80; req1_wdata = 32'h0;
    sb.push_back({2'b10, 32'h0, 1'b1});
    wait_setup(10, got, sa);
    run_access(40, 1'b0, n, st, av, rd, er);
    total++;
    if (!got || n != 16) begin bad++; $display("FAIL to_len: cycles %0d want 16", n); end
    e = sb.pop_front();
    total++;
    if ({av, rd, er} !== e) begin bad++; $display("FAIL to_ack: got %b %h %b want %b %h %b", av, rd, er, e.ack, e.rdata, e.err); end
    req1_valid = 1'b0;
    tick();
    total++;
    if ({p_sel, p_en, req1_ack, req0_ack} !== 4'b0000) begin
      bad++; $display("FAIL to_idle: got %b want 0000", {p_sel, p_en, req1_ack, req0_ack});
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    logic got, sa, er;
    logic [1:0] av;
    logic [31:0] rd;
    wait_cfg = 1000; rdata_cfg = 32'h0F0F_0F0F;
    req0_valid = 1'b1; req0_wr = 1'b0; req0_addr = 32'h500;
    wait_setup(10, got, sa);
    tick();
    tick();
    prst = 1'b1;
    tick();
    total++;
    if ({p_sel, p_en, req1_ack, req0_ack} !== 4'b0000) begin
      bad++; $display("FAIL rst_mid: got %b want 0000", {p_sel, p_en, req1_ack, req0_ack});
    end
    prst = 1'b0; wait_cfg = 0;
    req1_valid = 1'b1; req1_wr = 1'b0; req1_addr = 32'h600;
    sb.push_back({2'b01, 32'h0F0F_0F0F, 1'b0});
    wait_setup(10, got, sa);
    total++;
    if (!got || sa || p_addr !== 32'h500) begin
      bad++; $display("FAIL rst_regrant: setup %b stray_ack %b addr %h want 1 0 00000500", got, sa, p_addr);
    end
    wait_ack(10, got, av, rd, er);
    e = sb.pop_front();
    total++;
    if ({got, av, rd, er} !== {1'b1, e}) begin bad++; $display("FAIL rst_ack0: got %b %b %h %b want 1 %b %h %b", got, av, rd, er, e.ack, e.rdata, e.err); end
    req0_valid = 1'b0;
    sb.push_back({2'b10, 32'h0F0F_0F0F, 1'b0});
    wait_ack(10, got, av, rd, er);
    e = sb.pop_front();
    total++;
    if ({got, av, rd, er} !== {1'b1, e}) begin bad++; $display("FAIL rst_ack1: got %b %b %h %b want 1 %b %h %b", got, av, rd, er, e.ack, e.rdata, e.err); end
    req1_valid = 1'b0;
    tick();
  endtask

  task automatic test_toggle();
    exp_t e;
    logic got, sa, st, er;
    logic [1:0] av;
    logic [31:0] rd;
    int n;
    wait_cfg = 2; slverr_cfg = 1'b0; rdata_cfg = 32'h3C3C_3C3C;
    req0_valid = 1'b1; req0_wr = 1'b1; req0_addr = 32'h700; req0_wdata = 32'h0BAD_F00D;
    sb.push_back({2'b01, 32'h0, 1'b0});
    wait_setup(10, got, sa);
    run_access(20, 1'b1, n, st, av, rd, er);
    total++;
    if (!got || n != 3 || !st || p_addr !== 32'h700 || pw_data !== 32'h0BAD_F00D) begin
      bad++; $display("FAIL tog_xfer: cycles %0d stable %b addr %h data %h want 3 1 00000700 0badf00d", n, st, p_addr, pw_data);
    end
    e = sb.pop_front();
    total++;
    if ({av, rd, er} !== e) begin bad++; $display("FAIL tog_ack0: got %b %h %b want %b %h %b", av, rd, er, e.ack, e.rdata, e.err); end
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_wr = 1'b0; req1_addr = 32'h800;
    sb.push_back({2'b10, 32'h3C3C_3C3C, 1'b0});
    wait_setup(10, got, sa);
    total++;
    if (!got || p_addr !== 32'h800) begin bad++; $display("FAIL tog_grant1: got %h want 00000800", p_addr); end
    wait_ack(10, got, av, rd, er);
    e = sb.pop_front();
    total++;
    if ({got, av, rd, er} !== {1'b1, e}) begin bad++; $display("FAIL tog_ack1: got %b %b %h %b want 1 %b %h %b", got, av, rd, er, e.ack, e.rdata, e.err); end
    req1_valid = 1'b0;
    tick();
  endtask

  initial begin
    req0_valid = 1'b0; req0_wr = 1'b0; req0_addr = 32'h0; req0_wdata = 32'h0;
    req1_valid = 1'b0; req1_wr = 1'b0; req1_addr = 32'h0; req1_wdata = 32'h0;
    test_reset();
    test_single_read();
    test_round_robin();
    test_wait_write_err();
    test_timeout_edge();
    test_timeout();
    test_reset_mid();
    test_toggle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb_arbiter_master.md
APB_ARBITER_MASTER -- requirements
Module: apb_arbiter_master

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, the maximum number of ACCESS cycles with p_ready low before the transfer is aborted.
REQ-002 SHALL have ports:
- pclk  in  1  clock; all logic on the rising edge.
- prst  in  1  reset; synchronous, active-high.
- reqN_valid  in  1  request from requester N, N in {0,1}.
- reqN_wr  in  1  1 = write, 0 = read.
- reqN_addr  in  32  transfer address.
- reqN_wdata  in  32  write data.
- reqN_ack  out  1  one-cycle completion pulse.
- reqN_rdata  out  32  read data, valid while reqN_ack=1.
- reqN_err  out  1  error flag, valid while reqN_ack=1.
- p_sel, p_en, p_wr  out  1  APB control.
- p_addr, pw_data  out  32  APB address and write data.
- p_ready, pslverr  in  1  APB completion and slave error.
- pr_data  in  32  APB read data.
REQ-003 SHALL register every output; no combinational path from any input to any output.

Function
REQ-004 SHALL implement the FSM IDLE -> SETUP -> ACCESS -> DONE -> IDLE.
REQ-005 IDLE: if any reqN_valid=1, SHALL grant one requester, latch its wr/addr/wdata, and go to SETUP; otherwise stay in IDLE.
REQ-006 Arbitration SHALL be round-robin:
- Both valid: grant the requester other than last_grant.
- One valid: grant that requester.
- last_grant updates on every grant.
REQ-007 SETUP SHALL drive p_sel=1, p_en=0, with p_wr/p_addr/pw_data equal to the latched values; SETUP SHALL last exactly one cycle, then go to ACCESS.
REQ-008 ACCESS SHALL drive p_sel=1, p_en=1, with p_wr/p_addr/pw_data unchanged from SETUP.
REQ-009 In ACCESS with p_ready=1: SHALL capture pslverr, and capture pr_data if the transfer is a read (rdata=0 for writes), then go to DONE.
REQ-010 Timeout counter:
- Clears on entering ACCESS.
- Increments each ACCESS cycle with p_ready=0.
- On reaching TIMEOUT: go to DONE with err=1 and rdata=0.
- p_ready=1 on the same cycle as the count reaching TIMEOUT counts as normal completion.
REQ-011 DONE SHALL drive p_sel=0, p_en=0, and pulse reqN_ack=1 for the granted requester only, with reqN_rdata/reqN_err valid; then go to IDLE.
REQ-012 Latency:
- Request present in IDLE at cycle T gives SETUP at T+1 and ACCESS at T+2.
- p_ready sampled high at cycle A gives ack at A+1.
- Minimum transfer is 4 cycles from IDLE to IDLE.
REQ-013 A requester SHALL hold valid/wr/addr/wdata stable until its ack, and deassert valid at the clock edge that samples ack unless it issues a new request; the block SHALL NOT sample requests in DONE.
REQ-014 p_sel/p_en SHALL be 0 in IDLE and DONE; p_addr/p_wr/pw_data SHALL hold their last values outside SETUP/ACCESS.
REQ-015 reqN_ack SHALL never be high for both requesters in the same cycle, and never for more than one consecutive cycle per transfer.
REQ-016 Requests changing while the block is not in IDLE SHALL have no effect on the transfer in flight.

Reset
REQ-017 With prst=1 at a clock edge, the block SHALL take these values:
- State: IDLE.
- last_grant: 1, so requester 0 wins first.
- Timeout counter: 0.
- All outputs: 0.
REQ-018 Reset asserted mid-transfer SHALL abort with no ack generated; p_sel=0 from the following cycle.

Verification
REQ-019 The bench SHALL cover these scenarios:
- Single read, req0_addr=0x10, p_ready=1 in the first ACCESS cycle, pr_data=0xA5A5_0001: SETUP at T+1, ACCESS at T+2, req0_ack with req0_rdata=0xA5A5_0001 and req0_err=0 at T+3.
- Both requesters valid after reset, then held valid: grant order 0,1,0,1 over four transfers; p_addr matches the granted requester each time.
- Write with p_ready low for 3 ACCESS cycles and pslverr=1 on completion: ACCESS lasts 4 cycles, p_addr/pw_data stable throughout, ack with err=1 and rdata=0.
- p_ready held low (TIMEOUT=16): after 16 ACCESS cycles, DONE with err=1, rdata=0; returns to IDLE.
- prst=1 during ACCESS: p_sel=p_en=0 the next cycle, no ack, and requester 0 wins the next grant.
- req1 toggling during a req0 transfer: the req0 transfer completes unchanged; req1 is granted in the next IDLE.
